multi_port_reg_file: RTL
========================

MULTI_PORT_REG_FILE -- requirements
Module: multi_port_reg_file

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, meaning register count; a power of two and at least 4; AW = log2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, meaning number of read ports.
REQ-004 SHALL have port Clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port Reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port RS  input  NRD*AW  read addresses; port k occupies bits [k*AW +: AW].
REQ-007 SHALL have port ReadData  output  NRD*XLEN  read data; port k occupies bits [k*XLEN +: XLEN].
REQ-008 SHALL have port RsPending  output  NRD  scoreboard pending bit of each RS address.
REQ-009 SHALL have ports RD  input  AW, WriteData  input  XLEN, RegWrite  input  1; together these form the writeback port.
REQ-010 SHALL have ports Issue_valid  input  1, Issue_rd  input  AW, Issue_ready  output  1; together these form the destination-reservation handshake.
REQ-011 SHALL have ports Clear_req  input  1  (start bulk clear) and Busy  output  1  (clear sweep in progress).

Function
REQ-012 Reads SHALL be combinational, zero latency, one result per port.
REQ-013 A read of address 0 SHALL always return 0.
REQ-014 Write-through bypass SHALL apply: if RegWrite=1, RD!=0 and RD==RS[k], then ReadData[k] = WriteData in the same cycle.
REQ-015 A write SHALL commit on the rising edge when RegWrite=1, RD!=0 and Busy=0; writes to RD=0 SHALL be discarded.
REQ-016 The scoreboard SHALL hold one pending bit per register; pending[0] SHALL be hardwired to 0.
REQ-017 Issue_ready SHALL equal !Busy && !pending[Issue_rd] (WAW stall); Issue_rd=0 SHALL always be ready.
REQ-018 Issue_valid && Issue_ready SHALL set pending[Issue_rd] at the next edge.
REQ-019 A committed write SHALL clear pending[RD] at the next edge.
REQ-020 If an issue set and a write clear target the same register in the same cycle, the set SHALL win and pending SHALL be 1.
REQ-021 RsPending[k] SHALL be pending[RS[k]] && !(RegWrite && RD==RS[k]), so that a bypassed value counts as available.
REQ-022 The clear FSM SHALL have two states: IDLE and SWEEP.
REQ-023 IDLE -> SWEEP SHALL occur on Clear_req=1; on that edge index<=1 and all pending bits are cleared.
REQ-024 In SWEEP, each cycle SHALL write 0 to register[index] and increment index; at index=NREGS-1, after writing, the FSM SHALL return to IDLE.
REQ-025 A sweep SHALL take exactly NREGS-1 cycles, with Busy=1 for exactly those cycles.
REQ-026 While Busy=1: RegWrite SHALL be ignored, issues SHALL be refused, Clear_req SHALL be ignored, ReadData SHALL read as 0, and RsPending SHALL read as 0.
REQ-027 Clear_req and RegWrite in the same IDLE cycle: the write SHALL be dropped and the sweep SHALL start.

Reset
REQ-028 Reset_n=0 SHALL asynchronously force all registers to 0, all pending bits to 0, the FSM to IDLE and index to 1.
REQ-029 Under reset, ReadData SHALL read 0, RsPending 0, Busy 0, and Issue_ready 1.
REQ-030 Reset asserted mid-sweep SHALL abort the sweep immediately; after release the block SHALL be in IDLE.
REQ-031 Release of Reset_n SHALL need no synchroniser inside the block; the first active edge after release SHALL be a normal IDLE cycle.

Structure
REQ-032 Shared package regfile_pkg SHALL hold: default XLEN/NREGS/NRD constants, the FSM state enum {IDLE, SWEEP}, and the address-width function.
REQ-033 The scoreboard SHALL be one sub-module, regfile_scoreboard, covering pending bits, the set/clear priority, Issue_ready and RsPending.
REQ-034 Register storage, bypass and the clear FSM SHALL remain in the top module.

Verification
REQ-035 Write 0xDEAD_BEEF to x5, with RS[0]=5 in the same cycle -> ReadData[0]=0xDEAD_BEEF in that cycle and on every later read.
REQ-036 Write 0x1234 to x0 -> a read of x0 returns 0 and pending[0] stays 0.
REQ-037 Issue rd=7, then issue rd=7 again the next cycle -> Issue_ready=0; write x7 -> Issue_ready=1 one cycle later; RsPending for x7 goes 1, then 0.
REQ-038 Issue rd=9 and write x9 in the same cycle -> pending[9]=1 afterwards, and ReadData for x9 = WriteData.
REQ-039 Fill all registers with nonzero values, pulse Clear_req -> Busy=1 for NREGS-1 (31) cycles, RegWrite during the sweep is ignored, and all registers are 0 after the sweep.
REQ-040 Assert Reset_n=0 at sweep cycle 10 -> Busy=0 immediately, all registers 0, FSM in IDLE; a normal write succeeds right after release.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants, clear-FSM state type and address-width helper for the register file.
package regfile_pkg;

  localparam int XLEN_DEF  = 64;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF   = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } clr_state_e;

  // Number of address bits needed to index n entries (n is a power of two).
  function automatic int addr_width(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if (((n - 32'sd1) >> i) != 32'sd0) begin
        w = i + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for destination reservation: set on issue, clear on
// writeback, issue wins over writeback on the same register, bulk-clear on sweep start.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = NRD_DEF,
  localparam int AW    = addr_width(NREGS)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                busy_i,
  input  logic                clear_all_i,
  input  logic                issue_valid_i,
  input  logic [AW-1:0]       issue_rd_i,
  input  logic                wr_commit_i,
  input  logic                reg_write_i,
  input  logic [AW-1:0]       rd_i,
  input  logic [NRD*AW-1:0]   rs_i,
  output logic                issue_ready_o,
  output logic [NRD-1:0]      rs_pending_o
);

  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;
  logic             issue_fire;

  // A destination can be reserved only when no sweep runs and it is not already reserved.
  assign issue_ready_o = !busy_i && !pending_q[issue_rd_i];
  assign issue_fire    = issue_valid_i && issue_ready_o;

  // Next pending vector: writeback clear first so a same-cycle issue set overrides it.
  always_comb begin
    pending_d = pending_q;
    if (clear_all_i) begin
      pending_d = {NREGS{1'b0}};
    end else begin
      if (wr_commit_i) begin
        pending_d[rd_i] = 1'b0;
      end else begin
        pending_d[rd_i] = pending_q[rd_i];
      end
      if (issue_fire) begin
        pending_d[issue_rd_i] = 1'b1;
      end else begin
        pending_d[issue_rd_i] = pending_d[issue_rd_i];
      end
    end
    pending_d[0] = 1'b0;
  end

  // Pending-bit state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= {NREGS{1'b0}};
    end else begin
      pending_q <= pending_d;
    end
  end

  // Source pending flags; a value being written this cycle is bypassed, hence available.
  always_comb begin
    rs_pending_o = {NRD{1'b0}};
    for (int k = 0; k < NRD; k++) begin
      if (busy_i) begin
        rs_pending_o[k] = 1'b0;
      end else begin
        rs_pending_o[k] = pending_q[rs_i[k*AW +: AW]] &&
                          !(reg_write_i && (rd_i == rs_i[k*AW +: AW]));
      end
    end
  end

endmodule

// File: rtl/multi_port_reg_file.sv
// Multi-read-port register file with write-through bypass, destination scoreboard
// and a sequential bulk-clear sweep (one register zeroed per cycle).
module multi_port_reg_file
  import regfile_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = NRD_DEF,
  localparam int AW    = addr_width(NREGS)
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic [NRD*AW-1:0]    RS,
  output logic [NRD*XLEN-1:0]  ReadData,
  output logic [NRD-1:0]       RsPending,
  input  logic [AW-1:0]        RD,
  input  logic [XLEN-1:0]      WriteData,
  input  logic                 RegWrite,
  input  logic                 Issue_valid,
  input  logic [AW-1:0]        Issue_rd,
  output logic                 Issue_ready,
  input  logic                 Clear_req,
  output logic                 Busy
);

  localparam logic [AW-1:0] IDX_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] IDX_LAST = {AW{1'b1}};

  clr_state_e      state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [XLEN-1:0] regs_q [NREGS];
  logic            busy;
  logic            clear_start;
  logic            wr_commit;

  assign busy        = (state_q == SWEEP);
  assign Busy        = busy;
  assign clear_start = (state_q == IDLE) && Clear_req;
  // A clear request in the same idle cycle drops the write.
  assign wr_commit   = RegWrite && (RD != {AW{1'b0}}) && !busy && !Clear_req;

  // Clear FSM next state: start sweep at index 1, walk to the last register, return to idle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (Clear_req) begin
          state_d = SWEEP;
          idx_d   = IDX_ONE;
        end else begin
          state_d = IDLE;
          idx_d   = idx_q;
        end
      end
      SWEEP: begin
        if (idx_q == IDX_LAST) begin
          state_d = IDLE;
          idx_d   = IDX_ONE;
        end else begin
          state_d = SWEEP;
          idx_d   = idx_q + IDX_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = IDX_ONE;
      end
    endcase
  end

  // Clear FSM state and sweep index registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      idx_q   <= IDX_ONE;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Register storage: sweep zeroes one entry per cycle, otherwise normal writeback.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= {XLEN{1'b0}};
      end
    end else if (busy) begin
      regs_q[idx_q] <= {XLEN{1'b0}};
    end else if (wr_commit) begin
      regs_q[RD] <= WriteData;
    end else begin
      regs_q[RD] <= regs_q[RD];
    end
  end

  // Combinational read ports with x0 hardwired to zero and write-through bypass.
  always_comb begin
    ReadData = {(NRD*XLEN){1'b0}};
    for (int k = 0; k < NRD; k++) begin
      if (!Reset_n || busy) begin
        ReadData[k*XLEN +: XLEN] = {XLEN{1'b0}};
      end else if (RS[k*AW +: AW] == {AW{1'b0}}) begin
        ReadData[k*XLEN +: XLEN] = {XLEN{1'b0}};
      end else if (RegWrite && (RD == RS[k*AW +: AW])) begin
        ReadData[k*XLEN +: XLEN] = WriteData;
      end else begin
        ReadData[k*XLEN +: XLEN] = regs_q[RS[k*AW +: AW]];
      end
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD)
  ) u_scoreboard (
    .clk_i         (Clk),
    .rst_ni        (Reset_n),
    .busy_i        (busy),
    .clear_all_i   (clear_start),
    .issue_valid_i (Issue_valid),
    .issue_rd_i    (Issue_rd),
    .wr_commit_i   (wr_commit),
    .reg_write_i   (RegWrite),
    .rd_i          (RD),
    .rs_i          (RS),
    .issue_ready_o (Issue_ready),
    .rs_pending_o  (RsPending)
  );

endmodule
